// File: rtl/dcache_pkg.sv
// Shared geometry, tag-entry layout, flush FSM states and line-address helper for the
// 2-way, 16-set, 256-bit-line data cache.
package dcache_pkg;

    localparam int unsigned NUM_SETS  = 16;
    localparam int unsigned NUM_WAYS  = 2;
    localparam int unsigned LINE_W    = 256;
    localparam int unsigned TAG_W     = 25;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned IDX_W     = $clog2(NUM_SETS);
    localparam int unsigned WAY_W     = $clog2(NUM_WAYS);
    localparam int unsigned CNT_W     = IDX_W + WAY_W;
    localparam int unsigned OFF_W     = $clog2(LINE_W / 8);
    localparam int unsigned VALID_BIT = TAG_W - 1;
    localparam int unsigned DIRTY_BIT = TAG_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        SCAN,
        WB,
        CLEAR,
        DONE
    } flush_state_t;

    // Byte address of the first byte of a line: {tag, idx, zero offset}.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-3:0] tag,
                                                     input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_flush_mem_if.sv
// Write-back request holder: latches address/data on start and keeps the memory request
// asserted until the single-cycle acknowledge arrives.
module dcache_flush_mem_if
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_data,
    input  logic              mem_ack,
    output logic              mem_enable,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_data,
    output logic              wb_done
);

    logic              enable_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (start) begin
            enable_q <= 1'b1;
            addr_q   <= wb_addr;
            data_q   <= wb_data;
        end else if (enable_q && mem_ack) begin
            enable_q <= 1'b0;
        end
    end

    // Acks arriving while no request is outstanding are dropped here.
    assign wb_done    = enable_q & mem_ack;
    assign mem_enable = enable_q;
    assign mem_write  = enable_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Data-cache flush sequencer: stalls the CPU, walks all (set, way) entries and writes back
// valid+dirty lines. Define DCACHE_FLUSH_INV_EN to also invalidate entries (sram_inv_o).
module dcache_flush_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_req_i,
    input  logic              dcache_idle_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic              cpu_stall_o,
    output logic [IDX_W-1:0]  sram_idx_o,
    output logic [WAY_W-1:0]  sram_way_o,
    input  logic [TAG_W-1:0]  sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
`ifdef DCACHE_FLUSH_INV_EN
    output logic              sram_inv_o,
`endif
    output logic              sram_clr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_SETS * NUM_WAYS - 1);

    flush_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              entry_valid, entry_dirty;
    logic              wb_start, wb_done, advance;
    logic [ADDR_W-1:0] wb_addr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign entry_valid = sram_tag_i[VALID_BIT];
    assign entry_dirty = sram_tag_i[DIRTY_BIT];
    assign sram_idx_o  = cnt_q[IDX_W-1:0];
    assign sram_way_o  = cnt_q[CNT_W-1:IDX_W];
    assign wb_addr     = line_addr(sram_tag_i[TAG_W-3:0], sram_idx_o);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wb_start = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            IDLE:      if (flush_req_i) state_d = WAIT_IDLE;
            WAIT_IDLE: if (dcache_idle_i) state_d = SCAN;
            SCAN: begin
                if (entry_valid && entry_dirty) begin
                    wb_start = 1'b1;
                    state_d  = WB;
`ifdef DCACHE_FLUSH_INV_EN
                end else if (entry_valid) begin
                    state_d = CLEAR;
`endif
                end else begin
                    advance = 1'b1;
                end
            end
            WB:        if (wb_done) state_d = CLEAR;
            CLEAR:     advance = 1'b1;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        // Counter wraps to zero on the final entry, leaving it ready for the next flush.
        if (advance) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CNT_MAX) ? DONE : SCAN;
        end
    end

    assign flush_busy_o = (state_q != IDLE);
    assign cpu_stall_o  = flush_busy_o;
    assign flush_done_o = (state_q == DONE);

`ifdef DCACHE_FLUSH_INV_EN
    // CLEAR is also used for clean entries; only a written-back line needs its dirty strobe.
    logic wb_pending_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_pending_q <= 1'b0;
        end else if (wb_start) begin
            wb_pending_q <= 1'b1;
        end else if (state_q == CLEAR) begin
            wb_pending_q <= 1'b0;
        end
    end

    assign sram_clr_o = (state_q == CLEAR) && wb_pending_q;
    assign sram_inv_o = (state_q == CLEAR);
`else
    assign sram_clr_o = (state_q == CLEAR);
`endif

    dcache_flush_mem_if u_mem_if (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .start      (wb_start),
        .wb_addr    (wb_addr),
        .wb_data    (sram_data_i),
        .mem_ack    (mem_ack_i),
        .mem_enable (mem_enable_o),
        .mem_write  (mem_write_o),
        .mem_addr   (mem_addr_o),
        .mem_data   (mem_data_o),
        .wb_done    (wb_done)
    );

endmodule
